cfg_chain_loader: RTL and testbench

//   Column configuration loader. Sits directly north of the top clb_tile in each column.

---
 rtl/cfg_loader_pkg.sv | 19 +
 rtl/cfg_piso.sv | 27 ++
 rtl/cfg_chain_loader.sv | 115 +++++++++++
 tb/tb_cfg_chain_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state encoding and sizing helpers for the column config loader
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int WORD_W_DEFAULT = 32;

    // word_bits holds min(WORD_W, bits_left), so it must reach WORD_W itself
    function automatic int word_bits_width(input int word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/cfg_piso.sv
// rtl/cfg_piso.sv - parallel-in serial-out register, LSB emitted first
module cfg_piso #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr >> 1;
        end
    end

    assign dout = sr[0];

endmodule

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serialises bitstream words onto a column config chain, then commits it
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEFAULT,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              shift_out,
    output logic              set_out,
    output logic              cen_out,
    output logic              busy,
    output logic              done
);

    localparam int WB_W = word_bits_width(WORD_W);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bits_left, bits_left_nxt;
    logic [WB_W-1:0]  word_bits, word_bits_nxt;
    logic             piso_load, piso_shift, piso_bit;

    cfg_piso #(.WIDTH(WORD_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (cfg_word),
        .dout  (piso_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bits_left <= '0;
            word_bits <= '0;
        end else begin
            state     <= state_nxt;
            bits_left <= bits_left_nxt;
            word_bits <= word_bits_nxt;
        end
    end

    // All outputs decode from state only, so an async reset clears them at once
    always_comb begin
        state_nxt     = state;
        bits_left_nxt = bits_left;
        word_bits_nxt = word_bits;
        piso_load     = 1'b0;
        piso_shift    = 1'b0;
        cfg_ready     = 1'b0;
        shift_out     = 1'b0;
        set_out       = 1'b0;
        cen_out       = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_WAIT;
                    bits_left_nxt = CNT_W'(CHAIN_LEN);
                    word_bits_nxt = '0;
                end
            end
            ST_WAIT: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                shift_out = piso_bit;
                if (cfg_valid) begin
                    piso_load = 1'b1;
                    state_nxt = ST_SHIFT;
                    if (int'(bits_left) < WORD_W) begin
                        word_bits_nxt = WB_W'(bits_left);
                    end else begin
                        word_bits_nxt = WB_W'(WORD_W);
                    end
                end
            end
            ST_SHIFT: begin
                busy          = 1'b1;
                cen_out       = 1'b1;
                shift_out     = piso_bit;
                piso_shift    = 1'b1;
                bits_left_nxt = bits_left - CNT_W'(1);
                word_bits_nxt = word_bits - WB_W'(1);
                // Last chain bit wins over end-of-word: leftover high bits are dropped
                if (bits_left == CNT_W'(1)) begin
                    state_nxt = ST_SET;
                end else if (word_bits == WB_W'(1)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_SET: begin
                busy      = 1'b1;
                set_out   = 1'b1;
                cen_out   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb/tb_cfg_chain_loader.sv - randomized bench for cfg_chain_loader against a chain shift-register model
module tb_cfg_chain_loader;

    localparam int NI = 3;

    function automatic int len_of(input int k);
        return (k == 0) ? 64 : (k == 1) ? 40 : 8;
    endfunction

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NI-1:0]   start, cfg_valid, cfg_ready, shift_out, set_out, cen_out, busy, done;
    logic [31:0]     cfg_word [NI];
    logic [31:0]     wq [2];
    int              n_vec = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(len_of(g)), .CNT_W(11)) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .start     (start[g]),
            .cfg_word  (cfg_word[g]),
            .cfg_valid (cfg_valid[g]),
            .cfg_ready (cfg_ready[g]),
            .shift_out (shift_out[g]),
            .set_out   (set_out[g]),
            .cen_out   (cen_out[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [5:0] outs(input int k);
        return {cfg_ready[k], shift_out[k], set_out[k], cen_out[k], busy[k], done[k]};
    endfunction

    // Chain model: a len-bit register that takes shift_out at its head on every shift cycle
    task automatic run_load(input int k, input int nw, input int min_gap, input int max_gap,
                            input bit noise, input int rst_after);
        int          len = len_of(k);
        logic [63:0] mdl = '0;
        logic [63:0] want = '0;
        int          ptr = 0, gap = 0, shifts = 0, sets = 0, dones = 0, cyc = 0;
        int          bad = 0, acc = 0, waitc = 0, act = 0;
        int          first_acc = -1, set_cyc = -1, done_cyc = -1;
        bit          acc_prev = 1'b0, rdy_prev = 1'b0, so_prev = 1'b0, v;
        for (int i = 0; i < nw; i++) want |= 64'(wq[i]) << (32 * i);
        if (len < 64) want &= (64'd1 << len) - 64'd1;
        start[k]     = 1'b1;
        cfg_valid[k] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cfg_word[k]  = wq[0];
        while (dones == 0 && cyc < 2000) begin
            @(negedge clk);
            if (acc_prev && !cen_out[k]) bad++;
            if (cfg_ready[k] && cen_out[k]) bad++;
            if (cfg_ready[k] && rdy_prev && shift_out[k] != so_prev) bad++;
            if (busy[k] == done[k]) bad++;
            if (cen_out[k] && !set_out[k]) begin
                mdl = (mdl >> 1) | (64'(shift_out[k]) << (len - 1));
                shifts++;
            end
            if (set_out[k]) begin
                sets++;
                set_cyc = cyc;
                if (shift_out[k] || !cen_out[k]) bad++;
            end
            if (done[k]) begin
                dones++;
                done_cyc = cyc;
            end
            if (rst_after > 0 && shifts == rst_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_outputs", 64'(outs(k)), 64'd0);
                check("rst_partial", mdl >> (len - rst_after), want & ((64'd1 << rst_after) - 64'd1));
                start[k]     = 1'b0;
                cfg_valid[k] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (30) begin
                    @(negedge clk);
                    if (set_out[k] || done[k] || busy[k] || cen_out[k] || cfg_ready[k]) act++;
                end
                check("rst_quiet", act, 0);
                return;
            end
            if (dones != 0) break;
            if (cfg_ready[k] && first_acc >= 0) waitc++;
            if (ptr < nw && gap == 0) begin
                v           = 1'b1;
                cfg_word[k] = wq[ptr];
            end else begin
                v           = (noise && ptr >= nw) ? 1'($urandom_range(0, 1)) : 1'b0;
                cfg_word[k] = $urandom;
                if (gap > 0 && cfg_ready[k]) gap--;
            end
            cfg_valid[k] = v;
            start[k]     = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            acc_prev     = v && cfg_ready[k];
            if (acc_prev) begin
                acc++;
                ptr++;
                gap = $urandom_range(max_gap, min_gap);
                if (first_acc < 0) first_acc = cyc;
            end
            rdy_prev = cfg_ready[k];
            so_prev  = shift_out[k];
            cyc++;
        end
        start[k]     = 1'b0;
        cfg_valid[k] = 1'b0;
        check("no_timeout", 64'(cyc < 2000), 64'd1);
        check("shift_count", shifts, len);
        check("chain", mdl, want);
        check("words_taken", acc, nw);
        check("set_pulses", sets, 1);
        check("done_pulses", dones, 1);
        check("set_to_done", done_cyc - set_cyc, 1);
        check("latency", set_cyc - first_acc, len + waitc + 1);
        check("protocol", bad, 0);
        @(negedge clk);
        check("idle_after", 64'(outs(k)), 64'd0);
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        start     = '0;
        cfg_valid = '0;
        for (int i = 0; i < NI; i++) cfg_word[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check($sformatf("reset_outputs%0d", i), 64'(outs(i)), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        wq[0] = 32'hA5A5_0F0F; wq[1] = 32'hDEAD_BEEF;
        run_load(0, 2, 0, 0, 1'b0, 0);
        wq[0] = 32'hFFFF_FFFF; wq[1] = 32'h0000_00AB;
        run_load(1, 2, 0, 0, 1'b0, 0);
        wq[0] = 32'hA5A5_0F0F; wq[1] = 32'hDEAD_BEEF;
        run_load(0, 2, 5, 5, 1'b0, 0);
        run_load(0, 2, 0, 0, 1'b0, 20);
        run_load(0, 2, 0, 0, 1'b0, 0);
        run_load(0, 2, 0, 0, 1'b1, 0);
        wq[0] = 32'h0000_0081; wq[1] = 32'h0;
        run_load(2, 1, 0, 0, 1'b0, 0);

        repeat (30) begin
            k     = $urandom_range(0, NI - 1);
            wq[0] = $urandom;
            wq[1] = $urandom;
            run_load(k, (len_of(k) + 31) / 32, 0, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
